// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the block-RAM port arbiter.
// No logic; constants and encodings only.
// Imported by ram_rr_arbiter and rr_arb2.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 2;

  // Controller phase: clear pass after reset, then normal arbitration.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Which requester wins the next tie.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } prio_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: req[0]=A, req[1]=B.
// Latency: grant is combinational from req/en; prio updates on the next edge.
// Backpressure: en=0 blocks all grants and freezes prio; losers simply keep requesting.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output prio_t      prio
);

  // Pick a winner: a lone requester always wins, a tie goes to the prio holder.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio == REQ_A) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Hand priority to the side that did not win; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= REQ_A;
    end else if (gnt[0]) begin
      prio <= REQ_B;
    end else if (gnt[1]) begin
      prio <= REQ_A;
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one block-RAM write/read port pair between requesters A and B, after a post-reset clear pass.
// Latency: grant and RAM strobes are same-cycle; read data returns with rvalid one cycle after the grant.
// Backpressure: requests are held until gnt; no grants during the clear pass; one access per cycle total.
module ram_rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter bit                CLEAR_EN  = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_r_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam state_t            RST_STATE = CLEAR_EN ? ST_CLEAR : ST_RUN;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic              arb_en;
  logic [1:0]        arb_gnt;
  prio_t             arb_prio;

  // Arbitration is only live once the clear pass is done.
  assign arb_en = (state == ST_RUN);
  assign ready  = (state == ST_RUN);
  assign a_gnt  = arb_gnt[0];
  assign b_gnt  = arb_gnt[1];

  // Both requesters see the RAM read bus directly; rvalid says whose data it is.
  assign a_rdata = ram_r_data;
  assign b_rdata = ram_r_data;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({b_req, a_req}),
    .en   (arb_en),
    .gnt  (arb_gnt),
    .prio (arb_prio)
  );

  // State and clear-address registers; reset always restarts the clear at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Next state plus RAM port muxing; idle address/data lines are held at 0.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    ram_w_en     = 1'b0;
    ram_w_addr   = '0;
    ram_w_data   = '0;
    ram_r_en     = 1'b0;
    ram_r_addr   = '0;
    case (state)
      ST_CLEAR: begin
        ram_w_en     = 1'b1;
        ram_w_addr   = clr_addr;
        ram_w_data   = CLEAR_VAL;
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (arb_gnt[0]) begin
          if (a_we) begin
            ram_w_en   = 1'b1;
            ram_w_addr = a_addr;
            ram_w_data = a_wdata;
          end else begin
            ram_r_en   = 1'b1;
            ram_r_addr = a_addr;
          end
        end else if (arb_gnt[1]) begin
          if (b_we) begin
            ram_w_en   = 1'b1;
            ram_w_addr = b_addr;
            ram_w_data = b_wdata;
          end else begin
            ram_r_en   = 1'b1;
            ram_r_addr = b_addr;
          end
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  // Tag the RAM's registered read data for the side that issued the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

  // A tie must always resolve toward the current priority holder.
  tie_follows_prio: assert property (@(posedge clk) disable iff (rst)
    (arb_en && a_req && b_req) |-> (a_gnt == (arb_prio == REQ_A)));

endmodule

// File: tb/tb_ram_rr_arbiter.sv
module tb_ram_rr_arbiter;

  localparam int         AW   = 4;
  localparam int         DW   = 2;
  localparam logic [1:0] CVAL = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready;
  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_w_en, ram_r_en;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_w_data;
  logic [DW-1:0] ram_r_data = '0;

  int n_tests = 0, n_fail = 0;
  int sb_tests = 0, sb_fail = 0;

  always #5 clk = ~clk;

  ram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_EN(1'b1), .CLEAR_VAL(CVAL)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  // Block RAM model with registered read.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
  end

  // Scoreboard: expected read data queued at grant time, checked when rvalid shows up.
  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  logic [DW-1:0] ref_mem [16];
  int cyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (a_rvalid) begin
        sb_tests++;
        if (qa.size() == 0) begin
          sb_fail++; $display("FAIL a_rvalid_unexpected: got rvalid=1 want 0 at cycle %0d", cyc);
        end else begin
          e = qa.pop_front();
          if (e.cyc !== cyc || a_rdata !== e.data) begin
            sb_fail++;
            $display("FAIL a_read: got data=%0d cycle=%0d want data=%0d cycle=%0d", a_rdata, cyc, e.data, e.cyc);
          end
        end
      end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
        sb_tests++; sb_fail++;
        $display("FAIL a_rvalid_missing: got rvalid=0 want 1 at cycle %0d", qa[0].cyc);
        void'(qa.pop_front());
      end
      if (b_rvalid) begin
        sb_tests++;
        if (qb.size() == 0) begin
          sb_fail++; $display("FAIL b_rvalid_unexpected: got rvalid=1 want 0 at cycle %0d", cyc);
        end else begin
          e = qb.pop_front();
          if (e.cyc !== cyc || b_rdata !== e.data) begin
            sb_fail++;
            $display("FAIL b_read: got data=%0d cycle=%0d want data=%0d cycle=%0d", b_rdata, cyc, e.data, e.cyc);
          end
        end
      end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
        sb_tests++; sb_fail++;
        $display("FAIL b_rvalid_missing: got rvalid=0 want 1 at cycle %0d", qb[0].cyc);
        void'(qb.pop_front());
      end
      if (!rst) begin
        if (a_gnt) begin
          if (a_we) ref_mem[a_addr] = a_wdata;
          else qa.push_back('{ref_mem[a_addr], cyc + 1});
        end
        if (b_gnt) begin
          if (b_we) ref_mem[b_addr] = b_wdata;
          else qb.push_back('{ref_mem[b_addr], cyc + 1});
        end
      end else begin
        for (int i = 0; i < 16; i++) ref_mem[i] = CVAL;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; b_req = 0; b_we = 0;
  endtask

  task automatic solo_write(input bit side_b, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (side_b) begin b_req = 1; b_we = 1; b_addr = addr; b_wdata = data; end
    else        begin a_req = 1; a_we = 1; a_addr = addr; a_wdata = data; end
    next_cycle();
    idle();
  endtask

  // Reset values, clear pass sequencing, requests held during clear, first RUN grant.
  task automatic test_reset_clear();
    idle();
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got ready=%0b a_rv=%0b b_rv=%0b want 0 0 0", ready, a_rvalid, b_rvalid);
    end
    next_cycle();
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) begin a_req = 1; a_we = 0; a_addr = 4'd9; end
      @(negedge clk);
      n_tests++;
      if (ram_w_en !== 1'b1 || ram_w_addr !== AW'(i) || ram_w_data !== CVAL ||
          ready !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0 || ram_r_en !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_cycle%0d: got wen=%0b waddr=%0d wdata=%0d rdy=%0b agnt=%0b ren=%0b want 1 %0d %0d 0 0 0",
                 i, ram_w_en, ram_w_addr, ram_w_data, ready, a_gnt, ram_r_en, i, CVAL);
      end
      next_cycle();
    end
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1 || a_gnt !== 1'b1 || ram_r_en !== 1'b1 || ram_r_addr !== 4'd9 || ram_w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL first_run: got rdy=%0b agnt=%0b ren=%0b raddr=%0d wen=%0b want 1 1 1 9 0",
               ready, a_gnt, ram_r_en, ram_r_addr, ram_w_en);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_tests++;
    if (a_rvalid !== 1'b1 || a_rdata !== CVAL) begin
      n_fail++; $display("FAIL read_cleared: got rv=%0b data=%0d want 1 %0d", a_rvalid, a_rdata, CVAL);
    end
    next_cycle();
  endtask

  // A writes, B reads the same address on the very next cycle.
  task automatic test_write_then_read();
    a_req = 1; a_we = 1; a_addr = 4'd5; a_wdata = 2'd3;
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b1 || ram_w_en !== 1'b1 || ram_w_addr !== 4'd5 || ram_w_data !== 2'd3 || ram_r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL a_write: got gnt=%0b wen=%0b waddr=%0d wdata=%0d ren=%0b want 1 1 5 3 0",
               a_gnt, ram_w_en, ram_w_addr, ram_w_data, ram_r_en);
    end
    next_cycle();
    idle();
    b_req = 1; b_we = 0; b_addr = 4'd5;
    @(negedge clk);
    n_tests++;
    if (b_gnt !== 1'b1 || ram_r_en !== 1'b1 || ram_r_addr !== 4'd5 || ram_w_en !== 1'b0 ||
        ram_w_addr !== 4'd0 || ram_w_data !== 2'd0) begin
      n_fail++;
      $display("FAIL b_read: got gnt=%0b ren=%0b raddr=%0d wen=%0b waddr=%0d wdata=%0d want 1 1 5 0 0 0",
               b_gnt, ram_r_en, ram_r_addr, ram_w_en, ram_w_addr, ram_w_data);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_tests++;
    if (b_rvalid !== 1'b1 || b_rdata !== 2'd3 || a_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL b_rdata: got rv=%0b data=%0d a_rv=%0b want 1 3 0", b_rvalid, b_rdata, a_rvalid);
    end
    next_cycle();
  endtask

  // Both sides read continuously: strict A,B,A,B alternation, rvalid on the right side.
  task automatic test_back_to_back();
    solo_write(1'b0, 4'd1, 2'd1);
    solo_write(1'b0, 4'd2, 2'd3);
    solo_write(1'b1, 4'd3, 2'd0);
    a_req = 1; a_we = 0; a_addr = 4'd1;
    b_req = 1; b_we = 0; b_addr = 4'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_gnt !== (k % 2 == 0) || b_gnt !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL alt_gnt%0d: got a=%0b b=%0b want a=%0b b=%0b", k, a_gnt, b_gnt, k % 2 == 0, k % 2 == 1);
      end
      if (k > 0) begin
        n_tests++;
        if (a_rvalid !== ((k - 1) % 2 == 0) || b_rvalid !== ((k - 1) % 2 == 1)) begin
          n_fail++; $display("FAIL alt_rv%0d: got a=%0b b=%0b want a=%0b b=%0b", k, a_rvalid, b_rvalid,
                             (k - 1) % 2 == 0, (k - 1) % 2 == 1);
        end
      end
      next_cycle();
      if (k == 0) a_addr = 4'd2;
      if (k == 1) b_addr = 4'd1;
    end
    idle();
    @(negedge clk);
    n_tests++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b1 || b_rdata !== 2'd1) begin
      n_fail++; $display("FAIL alt_last: got a_rv=%0b b_rv=%0b data=%0d want 0 1 1", a_rvalid, b_rvalid, b_rdata);
    end
    next_cycle();
  endtask

  // B alone for three cycles, then a tie must go to A.
  task automatic test_b_only_then_tie();
    b_req = 1; b_we = 0;
    for (int k = 0; k < 3; k++) begin
      b_addr = AW'(k + 6);
      @(negedge clk);
      n_tests++;
      if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
        n_fail++; $display("FAIL b_only%0d: got a=%0b b=%0b want a=0 b=1", k, a_gnt, b_gnt);
      end
      next_cycle();
    end
    a_req = 1; a_we = 0; a_addr = 4'd5;
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++; $display("FAIL tie_after_b: got a=%0b b=%0b want a=1 b=0", a_gnt, b_gnt);
    end
    next_cycle();
    idle();
    repeat (2) next_cycle();
  endtask

  // Reset in the middle of the clear pass and in a read-grant cycle.
  task automatic test_reset_mid();
    rst = 1;
    next_cycle();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) rst = 1;
      @(negedge clk);
      n_tests++;
      if (ram_w_addr !== AW'(i) || ram_w_en !== 1'b1) begin
        n_fail++; $display("FAIL mid_clear%0d: got wen=%0b waddr=%0d want 1 %0d", i, ram_w_en, ram_w_addr, i);
      end
      next_cycle();
    end
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_tests++;
      if (ram_w_addr !== AW'(i) || ram_w_en !== 1'b1 || ready !== 1'b0) begin
        n_fail++; $display("FAIL restart_clear%0d: got wen=%0b waddr=%0d rdy=%0b want 1 %0d 0",
                           i, ram_w_en, ram_w_addr, ready, i);
      end
      next_cycle();
    end
    a_req = 1; a_we = 0; a_addr = 4'd4; rst = 1;
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b1 || ram_r_en !== 1'b1) begin
      n_fail++; $display("FAIL gnt_in_rst: got gnt=%0b ren=%0b want 1 1", a_gnt, ram_r_en);
    end
    next_cycle();
    idle();
    rst = 0;
    @(negedge clk);
    n_tests++;
    if (a_rvalid !== 1'b0 || ready !== 1'b0 || ram_w_en !== 1'b1 || ram_w_addr !== 4'd0) begin
      n_fail++; $display("FAIL no_rv_after_rst: got rv=%0b rdy=%0b wen=%0b waddr=%0d want 0 0 1 0",
                         a_rvalid, ready, ram_w_en, ram_w_addr);
    end
    repeat (16) next_cycle();
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reclear: got %0b want 1", ready);
    end
    next_cycle();
  endtask

  initial begin
    test_reset_clear();
    test_write_then_read();
    test_back_to_back();
    test_b_only_then_tie();
    test_reset_mid();
    repeat (3) next_cycle();
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++; $display("FAIL pending_reads: got %0d/%0d outstanding want 0/0", qa.size(), qb.size());
    end
    n_tests += sb_tests;
    n_fail  += sb_fail;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
